// File: rtl/rescaler.sv
// Rescaler at the end of the reciprocal path: undoes the input scaler's
// normalisation by shifting the core's estimate one bit per clock, saturating on left overflow.
module rescaler #(
  parameter int W  = 16,
  parameter int SW = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic signed [W-1:0] y_i,
  input  logic [SW-1:0]       shift_l_i,
  input  logic [SW-1:0]       shift_r_i,
  output logic signed [W-1:0] result_o,
  output logic                done_o,
  output logic                busy_o,
  output logic                sat_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SW-1:0] CNT_ZERO = SW'(0);
  localparam logic [SW-1:0] CNT_ONE  = SW'(1);

  // Largest magnitude of the matching sign, used when a left shift overflows.
  function automatic logic signed [W-1:0] clamp_val(input logic neg);
    clamp_val = neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction

  state_t              state_q, state_d;
  logic signed [W-1:0] work_q, work_d;
  logic signed [W-1:0] result_q, result_d;
  logic [SW-1:0]       cnt_q, cnt_d;
  logic                dir_left_q, dir_left_d;
  logic                sat_q, sat_d;
  logic                sat_out_q, sat_out_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic signed [SW:0]  net_s;
  logic [SW-1:0]       cnt_start_s;
  logic signed [W-1:0] shifted_s;
  logic                ovf_s;

  // Next-state and datapath logic for capture, shifting and completion.
  always_comb begin
    net_s       = $signed({1'b0, shift_l_i}) - $signed({1'b0, shift_r_i});
    cnt_start_s = net_s[SW] ? SW'(-net_s) : SW'(net_s);
    // Overflow when the bit about to become the sign differs from the sign.
    ovf_s       = dir_left_q && (work_q[W-1] != work_q[W-2]);
    if (dir_left_q) begin
      shifted_s = {work_q[W-2:0], 1'b0};
    end else begin
      shifted_s = {work_q[W-1], work_q[W-1:1]};
    end

    state_d    = state_q;
    work_d     = work_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    dir_left_d = dir_left_q;
    sat_d      = sat_q;
    sat_out_d  = sat_out_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          work_d     = y_i;
          cnt_d      = cnt_start_s;
          dir_left_d = !net_s[SW] && (|net_s);
          sat_d      = 1'b0;
          if (cnt_start_s == CNT_ZERO) begin
            state_d   = DONE;
            result_d  = y_i;
            sat_out_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (ovf_s) begin
          work_d    = clamp_val(work_q[W-1]);
          cnt_d     = CNT_ZERO;
          sat_d     = 1'b1;
          state_d   = DONE;
          result_d  = clamp_val(work_q[W-1]);
          sat_out_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          work_d = shifted_s;
          cnt_d  = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d   = DONE;
            result_d  = shifted_s;
            sat_out_d = sat_q;
            done_d    = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      work_q     <= {W{1'b0}};
      result_q   <= {W{1'b0}};
      cnt_q      <= CNT_ZERO;
      dir_left_q <= 1'b0;
      sat_q      <= 1'b0;
      sat_out_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
      dir_left_q <= dir_left_d;
      sat_q      <= sat_d;
      sat_out_q  <= sat_out_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign result_o = result_q;
  assign done_o   = done_q;
  assign busy_o   = busy_q;
  assign sat_o    = sat_out_q;

endmodule

// File: tb/tb_rescaler.sv
// Bench for rescaler: table of jobs with a result scoreboard, plus reset-abort
// and busy-ignore sequences.
module tb_rescaler;

  logic               clk;
  logic               rst;
  logic               start_i;
  logic signed [15:0] y_i;
  logic [2:0]         shift_l_i;
  logic [2:0]         shift_r_i;
  logic signed [15:0] result_o;
  logic               done_o;
  logic               busy_o;
  logic               sat_o;

  rescaler #(.W(16), .SW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .y_i       (y_i),
    .shift_l_i (shift_l_i),
    .shift_r_i (shift_r_i),
    .result_o  (result_o),
    .done_o    (done_o),
    .busy_o    (busy_o),
    .sat_o     (sat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int y;
    int l;
    int r;
    int res;
    int sat;
    int lat;
  } vec_t;

  typedef struct {
    int res;
    int sat;
    int lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Runs one job; optionally pulses a second start while busy, which must be ignored.
  task automatic run_job(input int y, input int l, input int r,
                         input int res, input int sat, input int lat,
                         input string name, input bit extra_start);
    exp_t e;
    exp_t got;
    int   edges;
    bit   seen;
    e.res = res; e.sat = sat; e.lat = lat;
    sb_q.push_back(e);
    @(negedge clk);
    start_i   = 1'b1;
    y_i       = 16'(y);
    shift_l_i = 3'(l);
    shift_r_i = 3'(r);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        check({name, "_busy"}, int'(busy_o), 1);
        if (extra_start) begin
          start_i   = 1'b1;
          y_i       = 16'sd100;
          shift_l_i = 3'd0;
          shift_r_i = 3'd0;
        end else begin
          start_i = 1'b0;
        end
      end else begin
        start_i = 1'b0;
      end
      if (done_o) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no done_o after %0d edges, expected one", name, edges);
      void'(sb_q.pop_front());
    end else begin
      got = sb_q.pop_front();
      check({name, "_result"}, int'(result_o), got.res);
      check({name, "_sat"}, int'(sat_o), got.sat);
      check({name, "_latency"}, edges, got.lat);
    end
    @(posedge clk);
    #1;
    check({name, "_done_pulse"}, int'(done_o), 0);
    check({name, "_busy_fall"}, int'(busy_o), 0);
  endtask

  vec_t vecs[14];
  int   pulses;

  initial begin
    vecs[0]  = '{16384,  0, 0,  16384, 0, 1};
    vecs[1]  = '{12000,  1, 0,  24000, 0, 2};
    vecs[2]  = '{-12001, 0, 3,  -1501, 0, 4};
    vecs[3]  = '{-20000, 1, 0, -32768, 1, 2};
    vecs[4]  = '{4096,   3, 1,  16384, 0, 3};
    vecs[5]  = '{100,    7, 0,  12800, 0, 8};
    vecs[6]  = '{-32768, 0, 7,   -256, 0, 8};
    vecs[7]  = '{1,      0, 1,      0, 0, 2};
    vecs[8]  = '{-1,     0, 5,     -1, 0, 6};
    vecs[9]  = '{8192,   1, 0,  16384, 0, 2};
    vecs[10] = '{8192,   2, 0,  32767, 1, 3};
    vecs[11] = '{-16384, 1, 0, -32768, 0, 2};
    vecs[12] = '{5,      4, 4,      5, 0, 1};
    vecs[13] = '{16384,  2, 0,  32767, 1, 2};

    rst       = 1'b0;
    start_i   = 1'b0;
    y_i       = 16'sd0;
    shift_l_i = 3'd0;
    shift_r_i = 3'd0;
    #12;
    check("reset_result", int'(result_o), 0);
    check("reset_done", int'(done_o), 0);
    check("reset_busy", int'(busy_o), 0);
    check("reset_sat", int'(sat_o), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_job(vecs[i].y, vecs[i].l, vecs[i].r, vecs[i].res, vecs[i].sat,
              vecs[i].lat, $sformatf("vec%0d", i), 1'b0);
    end

    // Reset in the middle of a 5-shift job: outputs clear at once, no done for it.
    @(negedge clk);
    start_i   = 1'b1;
    y_i       = 16'sd256;
    shift_l_i = 3'd5;
    shift_r_i = 3'd0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_result", int'(result_o), 0);
    check("abort_done", int'(done_o), 0);
    check("abort_busy", int'(busy_o), 0);
    check("abort_sat", int'(sat_o), 0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (done_o) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run_job(256, 5, 0, 8192, 0, 6, "after_abort", 1'b0);

    // Second start while busy must not spawn another job.
    run_job(4096, 3, 1, 16384, 0, 3, "busy_ignore", 1'b1);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (done_o || busy_o) pulses++;
    end
    check("busy_ignore_no_job", pulses, 0);
    check("busy_ignore_hold", int'(result_o), 16384);

    // New job accepted right after the previous done cycle.
    run_job(-12001, 0, 3, -1501, 0, 4, "back_to_back", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
